// File: rtl/srm_controller.sv
// -----------------------------------------------------------------------------
// srm_controller
//   Instruction decoder and control FSM for the Simple RISC Machine. It steps
//   each instruction through fetch, decode, execute and write-back. On every
//   cycle it drives all of the datapath, IR, PC, data-address and memory-command
//   controls.
//
//   This is a Moore machine: every output is a function of the registered state
//   and of the current instr fields. An asynchronous reset therefore drops all
//   write, memory and load strobes at once.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low; 0 forces state RST
//   instr      current instruction register contents
//   vsel       one-hot write-back source (C / PC / sximm8 / mdata)
//   readnum    register file read index
//   writenum   register file write index
//   write      register file write enable
//   loada      load datapath register A
//   loadb      load datapath register B
//   asel       1 = force 0 onto ALU A input
//   bsel       1 = sximm5 onto ALU B input
//   shift      shifter control
//   ALUop      00 ADD, 01 SUB, 10 AND, 11 NOT B
//   loadc      load result register C
//   loads      load Z/V/N status
//   load_ir    load IR from mdata
//   load_pc    load PC
//   reset_pc   PC next-value = 0
//   addr_sel   1 = memory address from PC, 0 = data-address register
//   load_addr  load data-address register from C[8:0]
//   mem_cmd    00 NONE, 01 READ, 10 WRITE
//   halted     FSM is parked in HALT
// -----------------------------------------------------------------------------
module srm_controller #(
  parameter logic [3:0] VSEL_C     = 4'b0001,
  parameter logic [3:0] VSEL_PC    = 4'b0010,
  parameter logic [3:0] VSEL_IMM8  = 4'b0100,
  parameter logic [3:0] VSEL_MDATA = 4'b1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  output logic [3:0]  vsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
  output logic        halted
);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
    S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG,
    S_ADDR, S_LD_ADDR, S_MEM_RD, S_LDR_WB,
    S_STR_RD, S_STR_C, S_MEM_WR, S_HALT
  } state_t;

  state_t state, state_next;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  assign opcode = instr[15:13];
  assign op     = instr[12:11];
  assign rn     = instr[10:8];
  assign rd     = instr[7:5];
  assign sh     = instr[4:3];
  assign rm     = instr[2:0];

  // Instruction classes shared by the EXEC outputs and the next-state logic.
  logic is_mov_reg, is_mvn, is_cmp, is_mem;
  assign is_mov_reg = ({opcode, op} == 5'b110_00);
  assign is_mvn     = ({opcode, op} == 5'b101_11);
  assign is_cmp     = ({opcode, op} == 5'b101_01);
  assign is_mem     = (opcode == 3'b011) || (opcode == 3'b100);

  // NOTE: registered state uses non-blocking assignment so that every flop
  // samples the pre-edge value; blocking here would race other clocked logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RST;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output and the next state get a default before the case, so
    // no path through it leaves a signal unassigned (which would infer a latch).
    state_next = state;
    vsel       = 4'b0000;
    readnum    = 3'b000;
    writenum   = 3'b000;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    shift      = 2'b00;
    ALUop      = 2'b00;
    loadc      = 1'b0;
    loads      = 1'b0;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    addr_sel   = 1'b0;
    load_addr  = 1'b0;
    mem_cmd    = MEM_NONE;
    halted     = 1'b0;

    unique case (state)
      S_RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        state_next = S_IF1;
      end
      S_IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        state_next = S_IF2;
      end
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        load_ir    = 1'b1;
        state_next = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case ({opcode, op})
          5'b110_10:                   state_next = S_WRITE_IMM;
          5'b110_00, 5'b101_11:        state_next = S_GET_B;
          5'b101_00, 5'b101_01,
          5'b101_10:                   state_next = S_GET_A;
          5'b011_00, 5'b100_00:        state_next = S_GET_A;
          default:                     state_next = S_HALT;
        endcase
      end
      S_WRITE_IMM: begin
        vsel       = VSEL_IMM8;
        writenum   = rn;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = is_mem ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        // MOV/MVN ignore A; MOV passes B through as 0 + B.
        asel       = is_mov_reg || is_mvn;
        shift      = sh;
        ALUop      = (opcode == 3'b110) ? 2'b00 : op;
        loadc      = 1'b1;
        loads      = is_cmp;
        state_next = is_cmp ? S_IF1 : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        vsel       = VSEL_C;
        writenum   = rd;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_ADDR: begin
        bsel       = 1'b1;
        loadc      = 1'b1;
        state_next = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        load_addr  = 1'b1;
        state_next = (opcode == 3'b011) ? S_MEM_RD : S_STR_RD;
      end
      S_MEM_RD: begin
        mem_cmd    = MEM_READ;
        state_next = S_LDR_WB;
      end
      S_LDR_WB: begin
        mem_cmd    = MEM_READ;
        vsel       = VSEL_MDATA;
        writenum   = rd;
        write      = 1'b1;
        state_next = S_IF1;
      end
      S_STR_RD: begin
        readnum    = rd;
        loadb      = 1'b1;
        state_next = S_STR_C;
      end
      S_STR_C: begin
        // Route Rd through the ALU as 0 + B so it lands in C for mdata-out.
        asel       = 1'b1;
        loadc      = 1'b1;
        state_next = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd    = MEM_WRITE;
        state_next = S_IF1;
      end
      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: doc/srm_controller.md
Name: srm_controller

Overview:
- Instruction decoder and control FSM for the Simple RISC Machine.
- Drives every control input of the existing datapath (vsel, loada/b, asel/bsel, shift, ALUop, loadc/s, readnum, writenum, write), plus the IR, PC, data-address and memory-command controls.
- Datapath is the responder; this block is the initiator that sequences fetch, decode, execute and write-back.
- Instr format: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0].

Parameters:
- VSEL_C, 4'b0001, vsel one-hot code selecting datapath C.
- VSEL_PC, 4'b0010, vsel code selecting PC.
- VSEL_IMM8, 4'b0100, vsel code selecting sximm8.
- VSEL_MDATA, 4'b1000, vsel code selecting mdata.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low; 0 forces state RST.
- instr, in, 16: current instruction register contents.
- vsel, out, 4: write-back source, one-hot.
- readnum, out, 3: register file read index.
- writenum, out, 3: register file write index.
- write, out, 1: register file write enable.
- loada, out, 1: load register A.
- loadb, out, 1: load register B.
- asel, out, 1: 1 selects 16'b0 into ALU A input.
- bsel, out, 1: 1 selects sximm5 into ALU B input.
- shift, out, 2: shifter control.
- ALUop, out, 2: 00 ADD, 01 SUB, 10 AND, 11 NOT B.
- loadc, out, 1: load result register C.
- loads, out, 1: load Z/V/N status.
- load_ir, out, 1: load IR from mdata.
- load_pc, out, 1: load PC.
- reset_pc, out, 1: PC next-value = 0.
- addr_sel, out, 1: 1 = memory address from PC; 0 = data-address register.
- load_addr, out, 1: load data-address register from C[8:0].
- mem_cmd, out, 2: 00 NONE, 01 READ, 10 WRITE.
- halted, out, 1: FSM is in HALT.

Behaviour:
- Moore FSM; state is registered.
- All outputs default to 0 (vsel=0000, mem_cmd=NONE); each state asserts only what is listed below.
- Async reset → RST. In RST: reset_pc=1, load_pc=1, all other outputs 0.
- RST → IF1 on the first clk after reset deasserts.

Fetch sequence:
- IF1: addr_sel=1, mem_cmd=READ.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1.
- UPDATE_PC: load_pc=1.
- DECODE: no outputs asserted.
- Fetch overhead: 4 cycles per instruction; every terminal state returns to IF1.

Execute paths from DECODE:
- MOV imm (110,10): WRITE_IMM: vsel=VSEL_IMM8, writenum=Rn, write=1.
- MOV reg (110,00): GET_B → EXEC → WRITE_REG.
- ADD (101,00) and AND (101,10): GET_A → GET_B → EXEC → WRITE_REG.
- CMP (101,01): GET_A → GET_B → EXEC; EXEC additionally asserts loads=1; then → IF1 with no write-back.
- MVN (101,11): GET_B → EXEC → WRITE_REG.

Execute-path state outputs:
- GET_A: readnum=Rn, loada=1.
- GET_B: readnum=Rm, loadb=1.
- EXEC: asel=1 for MOV/MVN, else 0; bsel=0; shift=sh; loadc=1.
- EXEC ALUop: 00 for MOV; op for the 101 group.
- WRITE_REG: vsel=VSEL_C, writenum=Rd, write=1.
- loads asserts only for CMP.

Memory paths:
- LDR (011,00): GET_A → ADDR → LD_ADDR → MEM_RD → LDR_WB.
- STR (100,00): GET_A → ADDR → LD_ADDR → STR_RD → STR_C → MEM_WR.

Memory-path state outputs:
- ADDR: asel=0, bsel=1, ALUop=00, shift=00, loadc=1.
- LD_ADDR: load_addr=1.
- MEM_RD: addr_sel=0, mem_cmd=READ.
- LDR_WB: addr_sel=0, mem_cmd=READ, vsel=VSEL_MDATA, writenum=Rd, write=1.
- STR_RD: readnum=Rd, loadb=1.
- STR_C: asel=1, bsel=0, shift=00, ALUop=00, loadc=1.
- MEM_WR: addr_sel=0, mem_cmd=WRITE.

Halt and illegal encodings:
- HALT (111,xx): enter HALT; halted=1; remain there regardless of instr until reset=0.
- Any other opcode/op combination → HALT.
- STR/LDR with op≠00 → HALT.

Boundary conditions:
- readnum/writenum are 000 in every state that does not list them.
- instr is sampled combinationally each state; IR is stable after IF2.
- Reset asserted mid-instruction (any state): immediate → RST with RST outputs. No partial write is issued after the asynchronous edge; write, mem_cmd and load_* drop combinationally.

Test Plan:
- Reset then fetch: hold reset=0 two cycles → reset_pc=1, load_pc=1. Release → IF1 (mem_cmd=01, addr_sel=1), IF2 (load_ir=1), UPDATE_PC (load_pc=1).
- MOV R0,#7 (instr 16'hD007): exactly 5 cycles IF1..WRITE_IMM. WRITE_IMM shows vsel=0100, writenum=0, write=1; with the datapath attached, R0=7.
- ADD R2,R1,R0,LSL#1 (16'hA148) with R1=2, R0=7: sequence GET_A(readnum=1) → GET_B(readnum=0) → EXEC(shift=01, ALUop=00, loadc=1) → WRITE_REG(vsel=0001, writenum=2) → R2=16.
- CMP R0,R0 (16'hA800) with R0=7: EXEC has loads=1, ALUop=01; no write pulse; Z=1 afterward.
- STR R1,[R0,#1] then LDR R3,[R0,#1] (R0=4, R1=2): MEM_WR drives mem_cmd=10, addr_sel=0, address 5; LDR_WB writes R3=2 with vsel=1000.
- HALT (16'hE000): halted=1 held 20 cycles with no mem_cmd. Asserting reset=0 mid-ADD (during EXEC) → RST within the same cycle, write never asserted.
